// File: rtl/flash_writer_pkg.sv
// Shared constants, state encoding and bus payload for the flash programming engine.
package flash_writer_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 22;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned POLL_W = 24;
    localparam int unsigned SR_W   = 8;

    // Intel CFI command codes, zero-extended to the bus width
    localparam logic [DATA_W-1:0] FLASH_CMD_ERASE   = 16'h0020;
    localparam logic [DATA_W-1:0] FLASH_CMD_CONFIRM = 16'h00D0;
    localparam logic [DATA_W-1:0] FLASH_CMD_PROG    = 16'h0040;
    localparam logic [DATA_W-1:0] FLASH_CMD_STATUS  = 16'h0070;
    localparam logic [DATA_W-1:0] FLASH_CMD_CLEAR   = 16'h0050;
    localparam logic [DATA_W-1:0] FLASH_CMD_READ    = 16'h00FF;

    localparam int unsigned SR_READY     = 7;
    localparam int unsigned SR_ERASE_ERR = 5;
    localparam int unsigned SR_PROG_ERR  = 4;
    localparam int unsigned SR_VPP_ERR   = 3;
    localparam int unsigned SR_LOCK_ERR  = 1;

    localparam logic [SR_W-1:0] SR_ERR_MASK = (SR_W'(1) << SR_ERASE_ERR)
                                            | (SR_W'(1) << SR_PROG_ERR)
                                            | (SR_W'(1) << SR_VPP_ERR)
                                            | (SR_W'(1) << SR_LOCK_ERR);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD1,
        S_CMD2,
        S_POLL_CMD,
        S_POLL_RD,
        S_CHECK,
        S_CLR,
        S_ARRAY,
        S_DONE
    } state_e;

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic logic sr_failed(input logic [SR_W-1:0] sr);
        return |(sr & SR_ERR_MASK);
    endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// Runs back-to-back flash bus cycles of WE_CYCLES+2 clocks while start is held.
module flash_bus_cycle
    import flash_writer_pkg::*;
#(
    parameter int unsigned WE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  bus_req_t          req,
    output logic              done_c,
    output logic              ce,
    output logic              oe,
    output logic              we,
    output logic              drive,
    output logic [DATA_W-1:0] dq
);

    localparam int unsigned LAST = WE_CYCLES + 1;

    logic [CNT_W-1:0] cnt;
    logic             strobe_c;

    assign done_c   = start && (cnt == CNT_W'(LAST));
    assign strobe_c = (cnt != '0) && (cnt <= CNT_W'(WE_CYCLES));

    // Pins are registered, so they trail the counter phase by one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            ce    <= 1'b1;
            oe    <= 1'b1;
            we    <= 1'b1;
            drive <= 1'b0;
            dq    <= '0;
        end else begin
            if (done_c || !start) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            ce    <= !start;
            we    <= !(start && req.write && strobe_c);
            oe    <= !(start && !req.write && strobe_c);
            drive <= start && req.write;
            dq    <= req.wdata;
        end
    end

endmodule

// File: rtl/flash_writer.sv
// Flash programming engine: word program / block erase with status polling.
module flash_writer
    import flash_writer_pkg::*;
#(
    parameter int unsigned       WE_CYCLES = 3,
    parameter logic [POLL_W-1:0] TIMEOUT   = 24'hFFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              need_to_work,
    input  logic              erase,
    input  logic [ADDR_W:1]   addr,
    input  logic [DATA_W-1:0] data,
    output logic              work_done,
    output logic              error,
    output logic [SR_W-1:0]   status_out,
    output logic [ADDR_W:0]   flash_addr,
    inout  wire  [DATA_W-1:0] flash_data,
    output logic              flash_byte,
    output logic              flash_vpen,
    output logic              flash_rp,
    output logic              flash_ce,
    output logic              flash_oe,
    output logic              flash_we
);

    state_e            state, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              erase_q;
    logic [POLL_W-1:0] poll_cnt;
    logic [POLL_W-1:0] poll_next;
    logic              timeout_c;

    bus_req_t          bus_req_c;
    logic              bus_start_c;
    logic              bus_done_c;
    logic              bus_drive;
    logic [DATA_W-1:0] bus_dq;

    logic              accept_c;
    logic              error_set_c;
    logic              poll_inc_c;
    logic              poll_clr_c;
    logic              sr_sample_c;

    assign poll_next  = poll_cnt + POLL_W'(1);
    assign timeout_c  = (poll_next >= TIMEOUT);

    assign flash_addr = {addr_q, 1'b0};
    assign flash_data = bus_drive ? bus_dq : {DATA_W{1'bz}};
    assign flash_byte = 1'b1;
    assign flash_vpen = 1'b1;
    assign flash_rp   = 1'b1;

    flash_bus_cycle #(
        .WE_CYCLES(WE_CYCLES)
    ) u_bus (
        .clk    (clk),
        .rst    (rst),
        .start  (bus_start_c),
        .req    (bus_req_c),
        .done_c (bus_done_c),
        .ce     (flash_ce),
        .oe     (flash_oe),
        .we     (flash_we),
        .drive  (bus_drive),
        .dq     (bus_dq)
    );

    always_comb begin
        state_d         = state;
        bus_start_c     = 1'b0;
        bus_req_c.write = 1'b1;
        bus_req_c.wdata = '0;
        accept_c        = 1'b0;
        error_set_c     = 1'b0;
        poll_inc_c      = 1'b0;
        poll_clr_c      = 1'b0;
        sr_sample_c     = 1'b0;

        case (state)
            S_IDLE: begin
                if (need_to_work) begin
                    accept_c = 1'b1;
                    state_d  = S_CMD1;
                end
            end
            S_CMD1: begin
                bus_start_c     = 1'b1;
                bus_req_c.wdata = erase_q ? FLASH_CMD_ERASE : FLASH_CMD_PROG;
                if (bus_done_c) state_d = S_CMD2;
            end
            S_CMD2: begin
                bus_start_c     = 1'b1;
                bus_req_c.wdata = erase_q ? FLASH_CMD_CONFIRM : data_q;
                if (bus_done_c) state_d = S_POLL_CMD;
            end
            S_POLL_CMD: begin
                bus_start_c     = 1'b1;
                bus_req_c.wdata = FLASH_CMD_STATUS;
                poll_clr_c      = 1'b1;
                if (bus_done_c) state_d = S_POLL_RD;
            end
            // Status is taken straight off the pins on the last oe-low clock.
            S_POLL_RD: begin
                bus_start_c     = 1'b1;
                bus_req_c.write = 1'b0;
                if (bus_done_c) begin
                    sr_sample_c = 1'b1;
                    if (flash_data[SR_READY]) begin
                        state_d = S_CHECK;
                    end else begin
                        poll_inc_c = 1'b1;
                        if (timeout_c) begin
                            error_set_c = 1'b1;
                            state_d     = S_CLR;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (sr_failed(status_out)) begin
                    error_set_c = 1'b1;
                    state_d     = S_CLR;
                end else begin
                    state_d = S_ARRAY;
                end
            end
            S_CLR: begin
                bus_start_c     = 1'b1;
                bus_req_c.wdata = FLASH_CMD_CLEAR;
                if (bus_done_c) state_d = S_ARRAY;
            end
            S_ARRAY: begin
                bus_start_c     = 1'b1;
                bus_req_c.wdata = FLASH_CMD_READ;
                if (bus_done_c) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            work_done  <= 1'b0;
            error      <= 1'b0;
            status_out <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            erase_q    <= 1'b0;
            poll_cnt   <= '0;
        end else begin
            state     <= state_d;
            work_done <= (state == S_DONE);
            if (accept_c) begin
                addr_q  <= addr;
                data_q  <= data;
                erase_q <= erase;
                error   <= 1'b0;
            end else if (error_set_c) begin
                error <= 1'b1;
            end
            if (sr_sample_c) status_out <= flash_data[SR_W-1:0];
            // Increments stop at TIMEOUT because the timeout exit follows the last one.
            if (poll_clr_c) begin
                poll_cnt <= '0;
            end else if (poll_inc_c) begin
                poll_cnt <= poll_next;
            end
        end
    end

endmodule
